// File: rtl/int_ctl.sv
// int_ctl: 65C02 interrupt/wait scheduler - pin synchronisers, NMI>IRQ arbitration,
// vector selection, in-service tracking and WAI/STP stalls.
module int_ctl #(
   parameter int          SYNC_STAGES = 2,
   parameter logic [15:0] NMI_VEC     = 16'hFFFA,
   parameter logic [15:0] RES_VEC     = 16'hFFFC,
   parameter logic [15:0] IRQ_VEC     = 16'hFFFE
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        irq_n,
   input  logic        nmi_n,
   input  logic        i_flag,
   input  logic        sync,
   input  logic        vec_fetch,
   input  logic        wai,
   input  logic        stp,
   output logic        irq,
   output logic [15:0] vector,
   output logic        rdy,
   output logic        in_service
);
   typedef enum logic [2:0] {RESV, IDLE, SERVICE, WAIT, STOP} state_t;

   state_t                 r_state, w_next;
   logic [SYNC_STAGES-1:0] r_irq_sync, r_nmi_sync;
   logic                   r_nmi_d, r_nmi_pend, r_irq;
   logic [15:0]            r_vector, w_vec;
   logic                   w_irq_s, w_nmi_s, w_edge, w_req, w_take, w_pend;

   assign w_irq_s = r_irq_sync[SYNC_STAGES-1];
   assign w_nmi_s = r_nmi_sync[SYNC_STAGES-1];
   assign w_edge  = r_nmi_d & ~w_nmi_s;
   assign w_req   = r_nmi_pend | (~w_irq_s & ~i_flag);
   // A new edge outranks the clear caused by taking the previously pending NMI
   assign w_pend  = (w_edge & (r_state != STOP)) | (r_nmi_pend & ~w_take);

   always_comb begin
      w_next = r_state;
      w_vec  = r_vector;
      w_take = 1'b0;
      case (r_state)
         RESV:
            if (vec_fetch) begin
               w_next = IDLE;
               w_vec  = IRQ_VEC;
            end
         IDLE:
            if (sync & r_irq) begin
               w_next = SERVICE;
               w_take = 1'b1;
               w_vec  = r_nmi_pend ? NMI_VEC : IRQ_VEC;
            end else if (stp) w_next = STOP;
            else if (wai) w_next = WAIT;
         SERVICE:
            if (vec_fetch) begin
               w_next = IDLE;
               w_vec  = IRQ_VEC;
            end
         WAIT:    w_next = (r_nmi_pend | ~w_irq_s) ? IDLE : WAIT;
         STOP:    w_next = STOP;
         default: w_next = RESV;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= RESV;
         r_irq_sync <= '1;
         r_nmi_sync <= '1;
         r_nmi_d    <= 1'b1;
         r_nmi_pend <= 1'b0;
         r_irq      <= 1'b0;
         r_vector   <= RES_VEC;
      end else begin
         r_state    <= w_next;
         r_irq_sync <= {r_irq_sync[SYNC_STAGES-2:0], irq_n};
         r_nmi_sync <= {r_nmi_sync[SYNC_STAGES-2:0], nmi_n};
         r_nmi_d    <= w_nmi_s;
         r_nmi_pend <= w_pend;
         // Qualify with the next state so irq is never seen high outside IDLE
         r_irq      <= w_req & (w_next == IDLE);
         r_vector   <= w_vec;
      end
   end

   assign irq        = r_irq;
   assign vector     = r_vector;
   assign rdy        = (r_state != WAIT) && (r_state != STOP);
   assign in_service = (r_state == SERVICE);
endmodule
